traffic_phase_ctrl: RTL



---
 rtl/traffic_phase_ctrl_pkg.sv | 54 +++++
 rtl/traffic_phase_ctrl_if.sv | 21 ++
 rtl/traffic_phase_ctrl_tick_gen.sv | 34 +++
 rtl/traffic_phase_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/traffic_phase_ctrl_pkg.sv
// ============================================================================
// traffic_pkg : phase/config encodings and default durations for the
//               two-way intersection phase sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

   typedef enum logic [2:0] {
      NG  = 3'd0,
      NY  = 3'd1,
      AR1 = 3'd2,
      WG  = 3'd3,
      WY  = 3'd4,
      AR2 = 3'd5
   } phase_e;

   typedef enum logic [1:0] {
      CFG_NG = 2'd0,
      CFG_WG = 2'd1,
      CFG_Y  = 2'd2,
      CFG_AR = 2'd3
   } cfg_sel_e;

   localparam int c_def_green  = 30;
   localparam int c_def_yellow = 3;
   localparam int c_def_allred = 2;
   localparam int c_ped_min    = 5;

   function automatic phase_e next_phase(input phase_e p);
      case (p)
         NG:      next_phase = NY;
         NY:      next_phase = AR1;
         AR1:     next_phase = WG;
         WG:      next_phase = WY;
         WY:      next_phase = AR2;
         default: next_phase = NG;
      endcase
   endfunction

   // Both yellows share one shadow register, as do both all-red phases.
   function automatic cfg_sel_e dur_sel(input phase_e p);
      case (p)
         NG:      dur_sel = CFG_NG;
         WG:      dur_sel = CFG_WG;
         NY, WY:  dur_sel = CFG_Y;
         default: dur_sel = CFG_AR;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_phase_ctrl_if.sv
// ============================================================================
// traffic_phase_ctrl_if : valid/ready duration-configuration port.
// Rev 1.0
// ============================================================================
`default_nettype none

interface traffic_phase_ctrl_if
   import traffic_pkg::*;
#(
   parameter int TIME_W = 10
);
   logic              cfg_valid;
   logic              cfg_ready;
   cfg_sel_e          cfg_sel;
   logic [TIME_W-1:0] cfg_time;

   modport master (output cfg_valid, output cfg_sel, output cfg_time, input  cfg_ready);
   modport slave  (input  cfg_valid, input  cfg_sel, input  cfg_time, output cfg_ready);
endinterface

`default_nettype wire

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// ============================================================================
// tick_gen : free-running prescaler producing a one-cycle tick every
//            CLK_DIV clocks (on the cycle where the count is CLK_DIV-1).
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
   parameter int CLK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [c_cnt_w-1:0] r_cnt;
   logic               w_wrap;

   assign w_wrap = (r_cnt == c_cnt_w'(CLK_DIV - 1));
   assign tick   = w_wrap;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
// ============================================================================
// traffic_phase_ctrl : six-phase north/west signal sequencer with run-time
//                      programmable durations and green-shortening requests.
// Rev 1.0
// ============================================================================
`default_nettype none

module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int CLK_DIV    = 50_000_000,
   parameter int TIME_W     = 10,
   parameter int DEF_GREEN  = c_def_green,
   parameter int DEF_YELLOW = c_def_yellow,
   parameter int DEF_ALLRED = c_def_allred,
   parameter int PED_MIN    = c_ped_min
) (
   input  logic                 clk,
   input  logic                 rst_n,
   traffic_phase_ctrl_if.slave  cfg,
   input  logic                 req_n,
   input  logic                 req_w,
   output logic                 north_red_led,
   output logic                 north_green_led,
   output logic                 north_yellow_led,
   output logic                 west_red_led,
   output logic                 west_green_led,
   output logic                 west_yellow_led,
   output logic [2:0]           phase,
   output logic [TIME_W-1:0]    remain
);
   localparam logic [TIME_W-1:0] c_one     = TIME_W'(1);
   localparam logic [TIME_W-1:0] c_ped     = TIME_W'(PED_MIN);
   localparam logic [TIME_W-1:0] c_dgreen  = TIME_W'(DEF_GREEN);
   localparam logic [TIME_W-1:0] c_dyellow = TIME_W'(DEF_YELLOW);
   localparam logic [TIME_W-1:0] c_dallred = TIME_W'(DEF_ALLRED);

   phase_e            r_state;
   phase_e            w_state_nxt;
   logic [TIME_W-1:0] r_remain;
   logic [TIME_W-1:0] w_remain_nxt;
   logic [TIME_W-1:0] r_dur [4];
   logic              r_latch_w;
   logic              r_latch_n;
   logic              w_latch_w_nxt;
   logic              w_latch_n_nxt;
   logic              r_cfg_ready;
   logic              w_tick;
   logic [TIME_W-1:0] w_raw_len;
   logic [TIME_W-1:0] w_enter_len;

   tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (w_tick)
   );

   // Entry length reads the shadow before any same-cycle write lands.
   assign w_raw_len   = r_dur[dur_sel(next_phase(r_state))];
   assign w_enter_len = (w_raw_len == '0) ? c_one : w_raw_len;

   assign cfg.cfg_ready = r_cfg_ready;
   assign phase         = r_state;
   assign remain        = r_remain;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= AR2;
         r_remain    <= c_dallred;
         r_latch_w   <= 1'b0;
         r_latch_n   <= 1'b0;
         r_cfg_ready <= 1'b0;
         r_dur[0]    <= c_dgreen;
         r_dur[1]    <= c_dgreen;
         r_dur[2]    <= c_dyellow;
         r_dur[3]    <= c_dallred;
      end else begin
         r_state     <= w_state_nxt;
         r_remain    <= w_remain_nxt;
         r_latch_w   <= w_latch_w_nxt;
         r_latch_n   <= w_latch_n_nxt;
         r_cfg_ready <= 1'b1;
         if (cfg.cfg_valid && r_cfg_ready) begin
            r_dur[cfg.cfg_sel] <= cfg.cfg_time;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_remain_nxt  = r_remain;
      w_latch_w_nxt = r_latch_w | req_w;
      w_latch_n_nxt = r_latch_n | req_n;

      // A tick outranks the request clamp; the clamp retries next cycle.
      if (w_tick) begin
         if (r_remain <= c_one) begin
            w_state_nxt  = next_phase(r_state);
            w_remain_nxt = w_enter_len;
         end else begin
            w_remain_nxt = r_remain - c_one;
         end
      end else if (r_state == NG && r_latch_w && r_remain > c_ped) begin
         w_remain_nxt = c_ped;
      end else if (r_state == WG && r_latch_n && r_remain > c_ped) begin
         w_remain_nxt = c_ped;
      end

      if (w_state_nxt == WG && r_state != WG) begin
         w_latch_w_nxt = 1'b0;
      end
      if (w_state_nxt == NG && r_state != NG) begin
         w_latch_n_nxt = 1'b0;
      end
   end

   always_comb begin
      north_green_led  = (r_state == NG);
      north_yellow_led = (r_state == NY);
      north_red_led    = !(north_green_led || north_yellow_led);
      west_green_led   = (r_state == WG);
      west_yellow_led  = (r_state == WY);
      west_red_led     = !(west_green_led || west_yellow_led);
   end
endmodule

`default_nettype wire
